// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: applies one single-bit SLL/SRL/SRA per clock
// up to a clamped distance, then pulses DONE with the result and last carry.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [CNTW-1:0]  N,
    input  logic             LA,
    input  logic             LR,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       dbg_state
);

    // Handshake: START is a request sampled only while not BUSY (IDLE or DONE);
    // it is accepted at that rising edge. DONE is a one-cycle pulse marking that
    // Y/C carry a fresh result; START during BUSY is dropped, never queued.

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNTW-1:0] MAX_N = CNTW'(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] w;
    logic [CNTW-1:0]  k;
    logic             la_r;
    logic             lr_r;

    logic [CNTW-1:0]  n_cl;
    logic [WIDTH-1:0] w_next;
    logic             carry;
    logic             accept;

    assign n_cl   = (N > MAX_N) ? MAX_N : N;
    assign accept = START && (state == S_IDLE || state == S_DONE);

    // Single-bit shifter, bit-exact with the shared datapath shifter.
    always_comb begin
        w_next = w;
        carry  = 1'b0;
        if (!lr_r) begin
            w_next = {w[WIDTH-2:0], 1'b0};
            carry  = w[WIDTH-1];
        end else if (la_r) begin
            w_next = {w[WIDTH-1], w[WIDTH-1:1]};
            carry  = w[0];
        end else begin
            w_next = {1'b0, w[WIDTH-1:1]};
            carry  = w[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            w     <= '0;
            k     <= '0;
            la_r  <= 1'b0;
            lr_r  <= 1'b0;
            Y     <= '0;
            C     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        w    <= A;
                        k    <= n_cl;
                        la_r <= LA;
                        lr_r <= LR;
                        if (n_cl == '0) begin
                            Y     <= A;
                            C     <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    w <= w_next;
                    k <= k - 1'b1;
                    // Final step loads the result registers on the same edge.
                    if (k == CNTW'(1)) begin
                        Y     <= w_next;
                        C     <= carry;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BUSY      = (state == S_SHIFT);
    assign DONE      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: driver pushes expected {Y,C} per
// operation, a negedge monitor pops and compares on every DONE pulse.
module tb_shift_sequencer;

    logic       clk;
    logic       reset;
    logic       START;
    logic [7:0] A;
    logic [3:0] N;
    logic       LA;
    logic       LR;
    logic [7:0] Y;
    logic       C;
    logic       BUSY;
    logic       DONE;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    logic [7:0] prev_y;

    shift_sequencer dut (
        .clk(clk), .reset(reset), .START(START), .A(A), .N(N), .LA(LA), .LR(LR),
        .Y(Y), .C(C), .BUSY(BUSY), .DONE(DONE), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && DONE) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Y=%0h C=%0b expected no DONE at %0t", Y, C, $time);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("result_y", {24'd0, Y}, {24'd0, e[8:1]});
                check("result_c", {31'd0, C}, {31'd0, e[0]});
            end
        end
    end

    // Driver: call just after a negedge. Returns at the negedge showing DONE.
    task automatic run_op(input string name, input logic [7:0] a, input logic [3:0] n,
                          input logic la, input logic lr, input logic [7:0] ey,
                          input logic ec, input bit disturb);
        int lat;
        int busy_cnt;
        int hold_bad;
        int exp_lat;
        bit seen;
        exp_lat  = (n > 4'd8) ? 8 : int'(n);
        lat      = 0;
        busy_cnt = 0;
        hold_bad = 0;
        seen     = 1'b0;
        START = 1'b1; A = a; N = n; LA = la; LR = lr;
        @(posedge clk);
        exp_q.push_back({ey, ec});
        #1;
        if (disturb) begin
            A  = 8'($urandom_range(0, 255));
            N  = 4'($urandom_range(1, 15));
            LA = ~la;
            LR = ~lr;
        end else begin
            START = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (DONE) begin
                seen = 1'b1;
                break;
            end
            lat++;
            if (BUSY) busy_cnt++;
            if (Y !== prev_y) hold_bad++;
        end
        START = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no DONE expected DONE within 20 cycles", name);
        end else begin
            check({name, "_latency"}, lat, exp_lat);
        end
        check({name, "_busy_cycles"}, busy_cnt, exp_lat);
        check({name, "_y_hold"}, hold_bad, 0);
        prev_y = ey;
    endtask

    initial begin
        reset = 1'b1; START = 1'b0; A = '0; N = '0; LA = 1'b0; LR = 1'b0;
        prev_y = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_y", {24'd0, Y}, 32'd0);
        check("reset_c", {31'd0, C}, 32'd0);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        check("reset_done", {31'd0, DONE}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("sll3",  8'hB5, 4'd3,  1'b0, 1'b0, 8'hA8, 1'b1, 1'b0);
        @(negedge clk);
        run_op("srl3",  8'hB5, 4'd3,  1'b0, 1'b1, 8'h16, 1'b1, 1'b0);
        @(negedge clk);
        run_op("sra3",  8'hB5, 4'd3,  1'b1, 1'b1, 8'hF6, 1'b1, 1'b0);
        @(negedge clk);
        run_op("n0",    8'hB5, 4'd0,  1'b0, 1'b0, 8'hB5, 1'b0, 1'b0);
        @(negedge clk);
        run_op("sra12", 8'h81, 4'd12, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        run_op("srl8",  8'h81, 4'd8,  1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        run_op("sll8",  8'h01, 4'd8,  1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        run_op("sra8p", 8'h7F, 4'd8,  1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        run_op("disturb", 8'hB5, 4'd3, 1'b0, 1'b0, 8'hA8, 1'b1, 1'b1);
        @(negedge clk);
        // Back-to-back: second START issued in the DONE cycle.
        run_op("b2b_a", 8'h3C, 4'd2, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0);
        run_op("b2b_b", 8'h81, 4'd1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0);
        @(negedge clk);

        // Reset two cycles into an N=5 shift: no DONE may follow.
        START = 1'b1; A = 8'hFF; N = 4'd5; LA = 1'b0; LR = 1'b0;
        @(posedge clk);
        #1 START = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", {31'd0, BUSY}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_reset_y", {24'd0, Y}, 32'd0);
        check("mid_reset_c", {31'd0, C}, 32'd0);
        check("mid_reset_busy", {31'd0, BUSY}, 32'd0);
        check("mid_reset_done", {31'd0, DONE}, 32'd0);
        check("mid_reset_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("post_reset_busy", {31'd0, BUSY}, 32'd0);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-bit shift controller built around the single-bit 8-bit shifter (SLL/SRL/SRA with carry-out).
- Accepts an operand, a shift amount (0–8) and a mode.
- Applies one single-bit shift per clock, then presents the result and the last bit shifted out with a one-cycle DONE pulse.
- Sits between the ALU/control unit and the shifter datapath, so that variable-distance shifts need no barrel shifter.

Parameters:
- WIDTH, 8, operand width. Fixed at 8 to match the shifter.
- CNTW, 4, shift-amount port width. Amounts above WIDTH clamp to WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- START  input  1  request pulse. Sampled only in IDLE or DONE.
- A  input  8  operand.
- N  input  4  shift distance, 0–15. Values >8 are treated as 8.
- LA  input  1  1 = arithmetic (SRA), 0 = logical. Meaningful only when LR=1.
- LR  input  1  1 = right shift, 0 = left shift (SLL).
- Y  output  8  result register.
- C  output  1  last bit shifted out.
- BUSY  output  1  high while in SHIFT.
- DONE  output  1  one-cycle pulse. Y/C are valid and new.

Behaviour:
- States: IDLE, SHIFT, DONE. Encoding is free.
- On reset, at any time including mid-operation, the block goes to IDLE immediately:
  - Y=0, C=0, BUSY=0, DONE=0.
  - Working register and counter cleared.
- START accepted (IDLE or DONE state, START=1 at a rising edge):
  - Working register W<=A.
  - Counter K<=min(N,8).
  - LA and LR latched. Later changes to A/N/LA/LR are ignored until the next accept.
  - If min(N,8)=0: go directly to DONE with Y<=A, C<=0.
  - Otherwise: go to SHIFT.
- SHIFT, on each edge:
  - W<=shift1(W) and Cw<=carry, where shift1 is the latched mode's single-bit shift:
    - SLL: {W[6:0],0}, carry W[7].
    - SRL: {0,W[7:1]}, carry W[0].
    - SRA: {W[7],W[7:1]}, carry W[0].
  - K<=K-1.
  - When K==1 at the edge: go to DONE and load Y<=shift1(W), C<=carry in the same edge.
- DONE:
  - DONE=1 for exactly one cycle, then IDLE.
  - START in DONE is accepted, giving back-to-back operation with no IDLE cycle.
- Latency: START sampled at edge k, so Y/C update and DONE=1 after edge k+N (N clamped). N=0 gives DONE after edge k.
- Y and C hold their value from the last DONE until the next completion or reset. They do not change during SHIFT.
- BUSY=1 exactly in SHIFT. START while BUSY=1 is ignored (no queueing).
- N=8 boundary behaviour:
  - SLL: Y=0, C=A[0].
  - SRL: Y=0, C=A[7].
  - SRA: Y={8{A[7]}}, C=A[7].
- The result must equal repeated application of the single-bit shifter. The single-bit shifter is instantiated, or its function reproduced bit-exactly.

Test Plan:
- Reset → all outputs 0. Assert reset 2 cycles into a N=5 SHIFT → IDLE next cycle, Y=0, C=0, BUSY=0, no DONE pulse.
- A=8'hB5, LR=0, N=3 → BUSY high 3 cycles; DONE after 3 edges with Y=8'hA8, C=1.
- A=8'hB5, LR=1, LA=0, N=3 → Y=8'h16, C=1. Same with LA=1 → Y=8'hF6, C=1.
- A=8'hB5, N=0 → DONE one edge after START, Y=8'hB5, C=0, BUSY never high. A=8'h81, SRA, N=12 → clamped to 8, Y=8'hFF, C=1. SRL N=8 → Y=8'h00, C=1.
- START held during SHIFT with different A/N → ignored, result unchanged. START asserted in the DONE cycle → new op starts with no IDLE gap, BUSY next cycle.
- Change LA/LR/A mid-SHIFT → result uses the values latched at accept. Y holds the previous result throughout SHIFT.
